// File: rtl/mem_txn_arbiter_if.sv
// Client-side and memory-side request/response bundle of mem_txn_arbiter.
// master = arbiter view, slave = environment (clients + memory) view.
interface mem_txn_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]      cli_req_valid;
    logic [N_REQ-1:0]      cli_req_ready;
    logic [N_REQ*5-1:0]    cli_req_warp_id;
    logic [N_REQ-1:0]      cli_req_we;
    logic [N_REQ*32-1:0]   cli_req_addr;
    logic [N_REQ*1024-1:0] cli_req_wdata;
    logic [N_REQ*32-1:0]   cli_req_mask;
    logic [N_REQ-1:0]      cli_resp_valid;
    logic [4:0]            cli_resp_warp_id;
    logic                  cli_resp_we;
    logic [1023:0]         cli_resp_rdata;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [4:0]            mem_req_warp_id;
    logic [15:0]           mem_req_transaction_id;
    logic                  mem_req_we;
    logic [31:0]           mem_req_addr;
    logic [1023:0]         mem_req_wdata;
    logic [31:0]           mem_req_mask;
    logic                  mem_resp_valid;
    logic [4:0]            mem_resp_warp_id;
    logic [15:0]           mem_resp_transaction_id;
    logic [1023:0]         mem_resp_rdata;

    modport master (
        input  cli_req_valid, cli_req_warp_id, cli_req_we, cli_req_addr, cli_req_wdata, cli_req_mask,
        output cli_req_ready, cli_resp_valid, cli_resp_warp_id, cli_resp_we, cli_resp_rdata,
        output mem_req_valid, mem_req_warp_id, mem_req_transaction_id, mem_req_we, mem_req_addr,
        output mem_req_wdata, mem_req_mask,
        input  mem_req_ready, mem_resp_valid, mem_resp_warp_id, mem_resp_transaction_id, mem_resp_rdata
    );

    modport slave (
        output cli_req_valid, cli_req_warp_id, cli_req_we, cli_req_addr, cli_req_wdata, cli_req_mask,
        input  cli_req_ready, cli_resp_valid, cli_resp_warp_id, cli_resp_we, cli_resp_rdata,
        input  mem_req_valid, mem_req_warp_id, mem_req_transaction_id, mem_req_we, mem_req_addr,
        input  mem_req_wdata, mem_req_mask,
        output mem_req_ready, mem_resp_valid, mem_resp_warp_id, mem_resp_transaction_id, mem_resp_rdata
    );
endinterface

// File: rtl/mem_txn_arbiter.sv
// Round-robin arbiter of N_REQ clients onto one memory port with a tag pool;
// out-of-order memory responses are routed back to the owning client by tag.
module mem_txn_arbiter #(
    parameter int N_REQ  = 4,
    parameter int N_TAGS = 16,
    parameter int TAG_W  = $clog2(N_TAGS)
) (
    input  logic              clk,
    input  logic              rst,
    mem_txn_arbiter_if.master bus,
    output logic [TAG_W:0]    outstanding,
    output logic              err_spurious
);
    localparam int CW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_TAGS-1:0] free_q, free_d;
    logic [CW-1:0]     tab_cli_q [N_TAGS];
    logic [N_TAGS-1:0] tab_we_q;
    logic [CW-1:0]     rr_q, rr_d;
    logic [TAG_W:0]    out_q, out_d;
    logic              err_q;

    logic              ob_vld_q;
    logic [4:0]        ob_warp_q;
    logic [TAG_W-1:0]  ob_tag_q;
    logic              ob_we_q;
    logic [31:0]       ob_addr_q, ob_mask_q;
    logic [1023:0]     ob_wdata_q;

    logic [N_REQ-1:0]  rs_oh_q, rs_oh_d;
    logic [4:0]        rs_warp_q;
    logic              rs_we_q;
    logic [1023:0]     rs_rdata_q;

    logic              can_issue, win_found, grant, rsp_hi, rsp_ok;
    logic [CW-1:0]     win_idx;
    logic [TAG_W-1:0]  alloc_tag, rsp_tag;
    logic [N_REQ-1:0]  ready_c;
    int unsigned       idx;

    always_comb begin
        can_issue = (!ob_vld_q || bus.mem_req_ready) && (|free_q) && !rst;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!win_found && bus.cli_req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = CW'(idx);
            end
        end
        grant   = can_issue && win_found;
        ready_c = '0;
        if (grant) ready_c[win_idx] = 1'b1;

        // Scan downward so the lowest free tag is the last one written.
        alloc_tag = '0;
        for (int unsigned t = N_TAGS; t > 0; t--)
            if (free_q[t-1]) alloc_tag = TAG_W'(t - 1);

        rsp_tag = bus.mem_resp_transaction_id[TAG_W-1:0];
        rsp_hi  = (bus.mem_resp_transaction_id >> TAG_W) != 16'd0;
        rsp_ok  = bus.mem_resp_valid && !rsp_hi && !free_q[rsp_tag];

        // Allocation reads free_q, so a tag freed this cycle is reusable only next cycle.
        free_d = free_q;
        if (grant)  free_d[alloc_tag] = 1'b0;
        if (rsp_ok) free_d[rsp_tag]   = 1'b1;

        out_d = out_q;
        if (grant && !rsp_ok)      out_d = out_q + 1'b1;
        else if (!grant && rsp_ok) out_d = out_q - 1'b1;

        rr_d = rr_q;
        if (grant) rr_d = (32'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;

        rs_oh_d = '0;
        if (rsp_ok) rs_oh_d[tab_cli_q[rsp_tag]] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_q     <= '1;
            tab_we_q   <= '0;
            for (int unsigned t = 0; t < N_TAGS; t++) tab_cli_q[t] <= '0;
            rr_q       <= '0;
            out_q      <= '0;
            err_q      <= 1'b0;
            ob_vld_q   <= 1'b0;
            ob_warp_q  <= '0;
            ob_tag_q   <= '0;
            ob_we_q    <= 1'b0;
            ob_addr_q  <= '0;
            ob_mask_q  <= '0;
            ob_wdata_q <= '0;
            rs_oh_q    <= '0;
            rs_warp_q  <= '0;
            rs_we_q    <= 1'b0;
            rs_rdata_q <= '0;
        end else begin
            free_q  <= free_d;
            rr_q    <= rr_d;
            out_q   <= out_d;
            rs_oh_q <= rs_oh_d;
            if (bus.mem_resp_valid && !rsp_ok) err_q <= 1'b1;
            if (grant) begin
                tab_cli_q[alloc_tag] <= win_idx;
                tab_we_q[alloc_tag]  <= bus.cli_req_we[win_idx];
                ob_vld_q   <= 1'b1;
                ob_tag_q   <= alloc_tag;
                ob_warp_q  <= bus.cli_req_warp_id[32'(win_idx)*5 +: 5];
                ob_we_q    <= bus.cli_req_we[win_idx];
                ob_addr_q  <= bus.cli_req_addr[32'(win_idx)*32 +: 32];
                ob_mask_q  <= bus.cli_req_mask[32'(win_idx)*32 +: 32];
                ob_wdata_q <= bus.cli_req_wdata[32'(win_idx)*1024 +: 1024];
            end else if (bus.mem_req_ready) begin
                ob_vld_q <= 1'b0;
            end
            if (rsp_ok) begin
                rs_warp_q  <= bus.mem_resp_warp_id;
                rs_we_q    <= tab_we_q[rsp_tag];
                rs_rdata_q <= bus.mem_resp_rdata;
            end
        end
    end

    assign bus.cli_req_ready          = ready_c;
    assign bus.cli_resp_valid         = rs_oh_q;
    assign bus.cli_resp_warp_id       = rs_warp_q;
    assign bus.cli_resp_we            = rs_we_q;
    assign bus.cli_resp_rdata         = rs_rdata_q;
    assign bus.mem_req_valid          = ob_vld_q;
    assign bus.mem_req_warp_id        = ob_warp_q;
    assign bus.mem_req_transaction_id = 16'(ob_tag_q);
    assign bus.mem_req_we             = ob_we_q;
    assign bus.mem_req_addr           = ob_addr_q;
    assign bus.mem_req_wdata          = ob_wdata_q;
    assign bus.mem_req_mask           = ob_mask_q;
    assign outstanding                = out_q;
    assign err_spurious               = err_q;
endmodule

// File: tb/tb_mem_txn_arbiter.sv
// Bench for mem_txn_arbiter (N_REQ=4, N_TAGS=8): directed vector table, hand
// sequences for exhaustion and reset, then random traffic against a tag-ownership model.
module tb_mem_txn_arbiter;
    localparam int NR = 4;
    localparam int NT = 8;
    localparam int TW = 3;

    logic clk = 1'b0;
    logic rst;
    logic [TW:0] outstanding;
    logic err_spurious;
    always #5 clk = ~clk;

    mem_txn_arbiter_if #(.N_REQ(NR)) bus ();
    mem_txn_arbiter #(.N_REQ(NR), .N_TAGS(NT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .outstanding(outstanding), .err_spurious(err_spurious)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [4:0]    c_warp [NR];
    logic          c_we   [NR];
    logic [31:0]   c_addr [NR];
    logic [31:0]   c_mask [NR];
    logic [1023:0] c_wdata[NR];

    // Model: who owns each tag (-1 = free), the one-entry memory-side buffer, last response.
    int            m_owner[NT];
    bit            m_owwe [NT];
    bit            m_ob_v;
    logic [4:0]    m_ob_warp;
    int            m_ob_tag;
    bit            m_ob_we;
    logic [31:0]   m_ob_addr, m_ob_mask;
    logic [1023:0] m_ob_wdata;
    int            m_rr;
    bit            m_err;
    logic [3:0]    m_resp_oh;
    logic [4:0]    m_resp_warp;
    bit            m_resp_we;
    logic [1023:0] m_resp_rdata;

    typedef struct {
        logic [3:0]  v;  logic rdy; logic rv; logic [15:0] rtid; logic [4:0] rwarp;
        logic [3:0]  e_rdy; logic e_mv; logic [15:0] e_tid; logic [3:0] e_out;
        logic [3:0]  e_resp; logic e_err;
    } vec_t;
    vec_t tbl[22];

    function automatic vec_t mk(input logic [3:0] v, input logic rv, input logic [15:0] rtid,
                                input logic [4:0] rwarp, input logic [3:0] e_rdy, input logic e_mv,
                                input logic [15:0] e_tid, input logic [3:0] e_out,
                                input logic [3:0] e_resp, input logic e_err);
        vec_t r;
        r.v = v; r.rdy = 1'b1; r.rv = rv; r.rtid = rtid; r.rwarp = rwarp;
        r.e_rdy = e_rdy; r.e_mv = e_mv; r.e_tid = e_tid; r.e_out = e_out;
        r.e_resp = e_resp; r.e_err = e_err;
        return r;
    endfunction

    function automatic int n_busy();
        int n = 0;
        for (int t = 0; t < NT; t++) if (m_owner[t] >= 0) n++;
        return n;
    endfunction

    function automatic int m_winner();
        if (rst || (m_ob_v && !bus.mem_req_ready) || n_busy() == NT) return -1;
        for (int k = 0; k < NR; k++)
            if (bus.cli_req_valid[(m_rr + k) % NR]) return (m_rr + k) % NR;
        return -1;
    endfunction

    task automatic m_reset();
        for (int t = 0; t < NT; t++) begin m_owner[t] = -1; m_owwe[t] = 1'b0; end
        m_ob_v = 1'b0; m_rr = 0; m_err = 1'b0; m_resp_oh = '0;
    endtask

    task automatic m_step();
        int w, a, id;
        bit ok;
        w = m_winner();
        a = -1;
        for (int t = NT - 1; t >= 0; t--) if (m_owner[t] < 0) a = t;
        id = int'(bus.mem_resp_transaction_id);
        ok = 1'b0;
        if (bus.mem_resp_valid && id < NT) ok = (m_owner[id] >= 0);
        m_resp_oh = '0;
        if (ok) begin
            m_resp_oh    = 4'(1 << m_owner[id]);
            m_resp_warp  = bus.mem_resp_warp_id;
            m_resp_we    = m_owwe[id];
            m_resp_rdata = bus.mem_resp_rdata;
        end else if (bus.mem_resp_valid) begin
            m_err = 1'b1;
        end
        if (m_ob_v && bus.mem_req_ready) m_ob_v = 1'b0;
        if (w >= 0) begin
            m_ob_v = 1'b1; m_ob_tag = a; m_ob_warp = c_warp[w]; m_ob_we = c_we[w];
            m_ob_addr = c_addr[w]; m_ob_mask = c_mask[w]; m_ob_wdata = c_wdata[w];
            m_owner[a] = w; m_owwe[a] = c_we[w];
            m_rr = (w + 1) % NR;
        end
        if (ok) m_owner[id] = -1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got ..%0h expected ..%0h (low 64 bits)", nm, act[63:0], exp[63:0]);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.cli_req_warp_id[i*5 +: 5]     = c_warp[i];
            bus.cli_req_we[i]                 = c_we[i];
            bus.cli_req_addr[i*32 +: 32]      = c_addr[i];
            bus.cli_req_mask[i*32 +: 32]      = c_mask[i];
            bus.cli_req_wdata[i*1024 +: 1024] = c_wdata[i];
        end
    endtask

    task automatic check_model();
        int w;
        logic [3:0] er;
        w  = m_winner();
        er = (w >= 0) ? 4'(1 << w) : 4'd0;
        chk("ready", bus.cli_req_ready, er);
        chk("req_valid", bus.mem_req_valid, m_ob_v);
        if (m_ob_v) begin
            chk("req_hdr", {bus.mem_req_warp_id, bus.mem_req_transaction_id, bus.mem_req_we,
                            bus.mem_req_addr, bus.mem_req_mask},
                {m_ob_warp, 16'(m_ob_tag), m_ob_we, m_ob_addr, m_ob_mask});
            chkw("req_wdata", bus.mem_req_wdata, m_ob_wdata);
        end
        chk("resp_valid", bus.cli_resp_valid, m_resp_oh);
        if (m_resp_oh != 4'd0) begin
            chk("resp_hdr", {bus.cli_resp_warp_id, bus.cli_resp_we}, {m_resp_warp, m_resp_we});
            chkw("resp_rdata", bus.cli_resp_rdata, m_resp_rdata);
        end
        chk("outstanding", outstanding, n_busy());
        chk("err_spurious", err_spurious, m_err);
    endtask

    task automatic cyc_pre();
        drive();
        if (rst) m_reset();
        #1;
        check_model();
    endtask

    task automatic cyc_post();
        @(posedge clk);
        if (rst) m_reset(); else m_step();
        @(negedge clk);
    endtask

    initial begin
        int q[$];
        bit lowmode;
        rst = 1'b1;
        lowmode = 1'b0;
        for (int i = 0; i < NR; i++) begin
            c_warp[i]  = 5'(i + 1);
            c_we[i]    = (i % 2 == 1);
            c_addr[i]  = (i == 2) ? 32'h0000_0100 : 32'h1000 * (i + 1);
            c_mask[i]  = 32'hFFFF_FFFF;
            c_wdata[i] = {32{32'(i + 32'hC0DE_0000)}};
        end
        bus.cli_req_valid = 4'b1011;
        bus.mem_req_ready = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_transaction_id = '0;
        bus.mem_resp_warp_id = '0;
        bus.mem_resp_rdata = {128{8'hA5}};
        m_reset();

        tbl[0]  = mk(4'b1011, 0, 0, 0, 4'b0001, 0, 0, 0, 4'b0000, 0);
        tbl[1]  = mk(4'b1011, 0, 0, 0, 4'b0010, 1, 0, 1, 4'b0000, 0);
        tbl[2]  = mk(4'b1011, 0, 0, 0, 4'b1000, 1, 1, 2, 4'b0000, 0);
        tbl[3]  = mk(4'b1011, 0, 0, 0, 4'b0001, 1, 2, 3, 4'b0000, 0);
        tbl[4]  = mk(4'b1011, 0, 0, 0, 4'b0010, 1, 3, 4, 4'b0000, 0);
        tbl[5]  = mk(4'b1011, 0, 0, 0, 4'b1000, 1, 4, 5, 4'b0000, 0);
        tbl[6]  = mk(4'b0000, 0, 0, 0, 4'b0000, 1, 5, 6, 4'b0000, 0);
        tbl[7]  = mk(4'b0000, 1, 4, 2, 4'b0000, 0, 0, 6, 4'b0000, 0);
        tbl[8]  = mk(4'b0000, 1, 2, 4, 4'b0000, 0, 0, 5, 4'b0010, 0);
        tbl[9]  = mk(4'b0000, 0, 0, 0, 4'b0000, 0, 0, 4, 4'b1000, 0);
        tbl[10] = mk(4'b0000, 1, 0, 1, 4'b0000, 0, 0, 4, 4'b0000, 0);
        tbl[11] = mk(4'b0000, 1, 1, 2, 4'b0000, 0, 0, 3, 4'b0001, 0);
        tbl[12] = mk(4'b0000, 1, 3, 1, 4'b0000, 0, 0, 2, 4'b0010, 0);
        tbl[13] = mk(4'b0000, 1, 5, 4, 4'b0000, 0, 0, 1, 4'b0001, 0);
        tbl[14] = mk(4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b1000, 0);
        tbl[15] = mk(4'b0100, 0, 0, 0, 4'b0100, 0, 0, 0, 4'b0000, 0);
        tbl[16] = mk(4'b0000, 0, 0, 0, 4'b0000, 1, 0, 1, 4'b0000, 0);
        tbl[17] = mk(4'b0000, 1, 0, 3, 4'b0000, 0, 0, 1, 4'b0000, 0);
        tbl[18] = mk(4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b0100, 0);
        tbl[19] = mk(4'b0000, 1, 7, 0, 4'b0000, 0, 0, 0, 4'b0000, 0);
        tbl[20] = mk(4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 1);
        tbl[21] = mk(4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 1);

        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            cyc_pre();
            chk("rst_ready", bus.cli_req_ready, 4'b0000);
            chk("rst_mvalid", bus.mem_req_valid, 1'b0);
            chk("rst_out", outstanding, 4'd0);
            cyc_post();
        end

        rst = 1'b0;
        for (int i = 0; i < 22; i++) begin
            bus.cli_req_valid           = tbl[i].v;
            bus.mem_req_ready           = tbl[i].rdy;
            bus.mem_resp_valid          = tbl[i].rv;
            bus.mem_resp_transaction_id = tbl[i].rtid;
            bus.mem_resp_warp_id        = tbl[i].rwarp;
            cyc_pre();
            chk("tbl_ready", bus.cli_req_ready, tbl[i].e_rdy);
            chk("tbl_mvalid", bus.mem_req_valid, tbl[i].e_mv);
            if (tbl[i].e_mv) chk("tbl_tid", bus.mem_req_transaction_id, tbl[i].e_tid);
            chk("tbl_out", outstanding, tbl[i].e_out);
            chk("tbl_resp", bus.cli_resp_valid, tbl[i].e_resp);
            chk("tbl_err", err_spurious, tbl[i].e_err);
            cyc_post();
        end

        // Exhaust all tags, free tag 2, confirm it is reissued only a cycle later.
        bus.cli_req_valid = 4'b1111;
        bus.mem_resp_valid = 1'b0;
        for (int e = 0; e < NT; e++) begin
            cyc_pre();
            if (e > 0) chk("exh_tid", bus.mem_req_transaction_id, 16'(e - 1));
            cyc_post();
        end
        cyc_pre();
        chk("exh_full_ready", bus.cli_req_ready, 4'b0000);
        chk("exh_out", outstanding, 4'd8);
        cyc_post();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_transaction_id = 16'd2;
        cyc_pre();
        chk("exh_free_ready", bus.cli_req_ready, 4'b0000);
        cyc_post();
        bus.mem_resp_valid = 1'b0;
        cyc_pre();
        chk("exh_regrant", bus.cli_req_ready, 4'b1000);
        chk("exh_resp", bus.cli_resp_valid, 4'b0010);
        cyc_post();
        bus.cli_req_valid = 4'b0000;
        cyc_pre();
        chk("exh_reuse_tid", bus.mem_req_transaction_id, 16'd2);
        cyc_post();

        // Reset with traffic in flight; a late response must then be spurious.
        bus.cli_req_valid = 4'b1111;
        rst = 1'b1;
        cyc_pre();
        chk("mid_rst_ready", bus.cli_req_ready, 4'b0000);
        chk("mid_rst_out", outstanding, 4'd0);
        chk("mid_rst_mvalid", bus.mem_req_valid, 1'b0);
        cyc_post();
        rst = 1'b0;
        bus.cli_req_valid = 4'b0000;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_transaction_id = 16'd3;
        cyc_pre();
        cyc_post();
        bus.mem_resp_valid = 1'b0;
        cyc_pre();
        chk("late_resp_err", err_spurious, 1'b1);
        chk("late_resp_valid", bus.cli_resp_valid, 4'b0000);
        cyc_post();

        rst = 1'b1;
        cyc_pre();
        cyc_post();
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) lowmode = ($urandom % 3 == 0);
            bus.mem_req_ready = lowmode ? ($urandom % 8 == 0) : ($urandom % 4 != 0);
            bus.cli_req_valid = 4'($urandom);
            for (int i = 0; i < NR; i++) begin
                c_warp[i] = 5'($urandom);
                c_we[i]   = 1'($urandom);
                c_addr[i] = $urandom;
                c_mask[i] = $urandom;
                for (int j = 0; j < 32; j++) c_wdata[i][j*32 +: 32] = $urandom;
            end
            for (int j = 0; j < 32; j++) bus.mem_resp_rdata[j*32 +: 32] = $urandom;
            bus.mem_resp_warp_id = 5'($urandom);
            bus.mem_resp_valid = 1'b0;
            q.delete();
            for (int t = 0; t < NT; t++) if (m_owner[t] >= 0) q.push_back(t);
            if (q.size() > 0 && $urandom % 3 == 0) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_transaction_id = 16'(q[$urandom_range(0, q.size() - 1)]);
            end else if (n > 2500 && $urandom % 40 == 0) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_transaction_id = ($urandom % 2 == 0) ? 16'(NT + $urandom_range(0, 500))
                                                                  : 16'($urandom_range(0, NT - 1));
            end
            cyc_pre();
            cyc_post();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
